// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB master/arbiter slice.
//   apb_state_e   : transfer FSM states
//   APB_*         : bus widths and slave count
//   SLV_SEL_*     : address bits that select one of APB_NSLV slaves
//   TIMEOUT_RDATA : read data returned when an access times out
//   slv_decode()  : address to one-hot slave select
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  localparam int unsigned APB_AW      = 32;
  localparam int unsigned APB_DW      = 32;
  localparam int unsigned APB_NSLV    = 8;
  localparam int unsigned SLV_SEL_MSB = 31;
  localparam int unsigned SLV_SEL_LSB = 29;

  localparam logic [APB_DW-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  function automatic logic [APB_NSLV-1:0] slv_decode(input logic [APB_AW-1:0] addr);
    logic [APB_NSLV-1:0] sel;
    sel = '0;
    sel[addr[SLV_SEL_MSB:SLV_SEL_LSB]] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req   : request vector, one bit per requester
//   i_ptr   : highest-priority index for this pick
//   o_grant : one-hot grant (zero when no request)
//   o_idx   : index of the granted requester
//   o_any   : at least one request present
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned REQ_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [REQ_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [REQ_W-1:0]   o_idx,
  output logic               o_any
);

  logic [REQ_W-1:0] w_cand;

  // Walk from i_ptr upward, wrapping modulo NUM_REQ; first set bit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = REQ_W'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: multi-requester APB master with round-robin arbitration.
//   pclk/preset          : clock, synchronous active-high reset
//   req_valid/write      : per-requester request, held until req_ready
//   req_addr/wdata       : packed 32-bit fields, requester i at [32i+31:32i]
//   req_ready            : one-cycle accept pulse to the granted requester
//   rsp_valid            : one-cycle completion pulse to the owner
//   rsp_rdata/rsp_err    : completion data/status, held between pulses
//   paddr..pwdata        : APB master outputs; pselx one-hot from paddr[31:29]
//   prdata/pready/pslverr: APB slave responses
// Optional: define APB_MASTER_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYCLES cycles (rsp_err=1, rsp_rdata=TIMEOUT_RDATA on expiry).
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned REQ_W          = $clog2(NUM_REQ),
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*32-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [APB_DW-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [APB_AW-1:0]       paddr,
  output logic [APB_NSLV-1:0]     pselx,
  output logic                    penable,
  output logic                    pwrite,
  output logic [APB_DW-1:0]       pwdata,
  input  logic [APB_DW-1:0]       prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || REQ_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master_arb: illegal parameter combination");
  end

  apb_state_e         r_state;
  apb_state_e         w_next;
  logic [REQ_W-1:0]   r_owner;
  logic [REQ_W-1:0]   r_ptr;
  logic [APB_AW-1:0]  r_addr;
  logic [APB_DW-1:0]  r_wdata;
  logic               r_write;
  logic [APB_DW-1:0]  r_rdata;
  logic               r_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [REQ_W-1:0]   w_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_tmo_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Gating with preset keeps a reset cycle from handing out an accept pulse
  // for a request that the reset then discards.
  assign w_accept = (r_state == IDLE) && w_any && !preset;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Fires on the ACCESS cycle whose stall would bring the count to the limit;
  // a same-cycle pready takes precedence because it is excluded here.
  assign w_tmo_hit = (r_state == ACCESS) && !pready &&
                     ((32'(r_tmo_cnt) + 32'd1) >= TIMEOUT_CYCLES);

  always_ff @(posedge pclk) begin
    if (preset || r_state == SETUP) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ACCESS && !pready) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_idx;
        r_addr  <= req_addr[w_idx*APB_AW +: APB_AW];
        r_wdata <= req_wdata[w_idx*APB_DW +: APB_DW];
        r_write <= req_write[w_idx];
      end
      if (r_state == ACCESS) begin
        if (pready) begin
          r_rdata <= r_write ? '0 : prdata;
          r_err   <= pslverr;
        end else if (w_tmo_hit) begin
          r_rdata <= TIMEOUT_RDATA;
          r_err   <= 1'b1;
        end
      end
      if (r_state == RESP) begin
        r_ptr <= REQ_W'((32'(r_owner) + 32'd1) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    pselx     = '0;
    penable   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready = w_grant;
          w_next    = SETUP;
        end
      end
      SETUP: begin
        pselx  = slv_decode(r_addr);
        w_next = ACCESS;
      end
      ACCESS: begin
        pselx   = slv_decode(r_addr);
        penable = 1'b1;
        if (pready || w_tmo_hit) begin
          w_next = RESP;
        end
      end
      RESP: begin
        rsp_valid[r_owner] = 1'b1;
        w_next             = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign paddr     = r_addr;
  assign pwrite    = r_write;
  assign pwdata    = r_wdata;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: bench for apb_master_arb with a transaction-level model,
// an APB slave with configurable wait/error, and per-requester request queues.
module tb_apb_master_arb;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic              pclk = 1'b0;
  logic              preset;
  logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [N*32-1:0]   req_addr, req_wdata;
  logic [31:0]       rsp_rdata, paddr, pwdata, prdata;
  logic              rsp_err, penable, pwrite, pready, pslverr;
  logic [7:0]        pselx;

  apb_master_arb #(
    .NUM_REQ        (N),
    .REQ_W          (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .paddr     (paddr),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          o;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } rq_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic [7:0]  sel;
    int          en;
  } rec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  rq_t         rq[$];
  rec_t        recs[$];
  int          glog_id[$];
  int          glog_cyc[$];
  logic [N-1:0] seen_ready = '0;
  int          s_wait = 0;
  logic        s_err  = 1'b0;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] mmem [logic [31:0]];

  // model state: one outstanding transfer, described by its age since grant
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_age  = 0;
  int          m_acc  = 0;
  int          m_en   = 0;
  int          m_ptr  = 0;
  int          m_own  = 0;
  logic        m_w    = 1'b0;
  logic [31:0] m_a    = '0;
  logic [31:0] m_d    = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err  = 1'b0;
  logic [7:0]  m_sel  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [7:0] sel_of(input logic [31:0] a);
    logic [2:0] s;
    s = a[31:29];
    return 8'h01 << s;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mmem.exists(a)) return mmem[a];
    return 32'h0012_3456;
  endfunction

  task automatic push(input int o, input logic w, input logic [31:0] a, input logic [31:0] d);
    rq_t r;
    r.o = o; r.w = w; r.a = a; r.d = d;
    rq.push_back(r);
  endtask

  // requester agents: drop on accept, then load the next queued item
  initial begin : drv
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    forever begin
      @(posedge pclk); #1;
      for (int i = 0; i < N; i++) begin
        if (seen_ready[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          for (int k = 0; k < rq.size(); k++) begin
            if (rq[k].o == i) begin
              req_valid[i]           = 1'b1;
              req_write[i]           = rq[k].w;
              req_addr[i*32 +: 32]   = rq[k].a;
              req_wdata[i*32 +: 32]  = rq[k].d;
              rq.delete(k);
              break;
            end
          end
        end
      end
    end
  end

  // APB slave: pready after s_wait stalled ACCESS cycles
  initial begin : slave
    int acc_n;
    acc_n   = 0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    forever begin
      @(posedge pclk); #1;
      if (penable && pselx != '0) begin
        if (acc_n >= s_wait) begin
          pready  = 1'b1;
          pslverr = s_err;
          if (pwrite) begin
            smem[paddr] = pwdata;
            prdata      = 32'hFFFF_FFFF;
          end else begin
            prdata = smem.exists(paddr) ? smem[paddr] : 32'h0012_3456;
          end
        end else begin
          pready = 1'b0;
          prdata = 32'h0BAD_0BAD;
        end
        acc_n++;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        acc_n   = 0;
      end
    end
  end

  initial begin : compare
    logic [N-1:0] e_ready, e_rv;
    logic [7:0]   e_sel;
    logic         e_en;
    int           win;
    rec_t         r;
    forever begin
      @(negedge pclk);
      cyc++;
      e_ready = '0;
      e_rv    = '0;
      e_sel   = '0;
      e_en    = 1'b0;
      win     = 0;
      if (!m_busy) begin
        if (!preset && req_valid != '0) begin
          win = pick(req_valid, m_ptr);
          e_ready[win] = 1'b1;
        end
      end else if (m_age == 1) begin
        e_sel = sel_of(m_a);
      end else if (!m_done) begin
        e_sel = sel_of(m_a);
        e_en  = 1'b1;
      end else begin
        e_rv[m_own] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("pselx", 32'(pselx), 32'(e_sel));
      chk("penable", 32'(penable), 32'(e_en));
      if (e_sel != '0) begin
        chk("paddr", paddr, m_a);
        chk("pwrite", 32'(pwrite), 32'(m_w));
        if (m_w) chk("pwdata", pwdata, m_d);
      end
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));

      seen_ready = req_ready;
      if (m_busy && penable) m_en++;
      if (m_busy && m_age == 1) m_sel = pselx;

      if (preset) begin
        m_busy  = 1'b0;
        m_ptr   = 0;
        m_rdata = '0;
        m_err   = 1'b0;
      end else if (!m_busy) begin
        if (req_valid != '0) begin
          m_busy = 1'b1;
          m_done = 1'b0;
          m_age  = 1;
          m_acc  = 0;
          m_en   = 0;
          m_own  = win;
          m_w    = req_write[win];
          m_a    = req_addr[win*32 +: 32];
          m_d    = req_wdata[win*32 +: 32];
          if (m_w) mmem[m_a] = m_d;
          glog_id.push_back(win);
          glog_cyc.push_back(cyc);
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (!m_done) begin
        m_acc++;
        if (pready) begin
          m_done  = 1'b1;
          m_rdata = m_w ? 32'h0 : mem_rd(m_a);
          m_err   = pslverr;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (m_acc == TMO) begin
          m_done  = 1'b1;
          m_rdata = 32'hDEAD_BEEF;
          m_err   = 1'b1;
        end
`endif
      end else begin
        r.d = rsp_rdata; r.e = rsp_err; r.sel = m_sel; r.en = m_en;
        recs.push_back(r);
        m_busy = 1'b0;
        m_ptr  = (m_own + 1) % N;
      end
    end
  end

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    do begin
      @(negedge pclk); #1;
      k++;
    end while (!(rq.size() == 0 && req_valid == '0 && !m_busy) && k < lim);
    n_tests++;
    if (k >= lim) begin
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", lim);
    end
  endtask

  task automatic clear_logs();
    recs.delete();
    glog_id.delete();
    glog_cyc.delete();
  endtask

  initial begin : main
    int k, pulses;
    preset = 1'b1;
    // all four requesters pending from reset; requester 0 has a second item
    push(0, 1'b1, 32'h0000_0010, 32'hA5A5_1234);
    push(1, 1'b1, 32'hE000_0004, 32'h1111_1111);
    push(2, 1'b0, 32'h2000_0000, 32'h0);
    push(3, 1'b1, 32'h0000_0020, 32'h3333_3333);
    push(0, 1'b0, 32'h0000_0010, 32'h0);
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pselx", 32'(pselx), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    preset = 1'b0;
    wait_idle(200);

    chk("n_grants", glog_id.size(), 5);
    chk("n_rsps", recs.size(), 5);
    if (glog_id.size() == 5 && recs.size() == 5) begin
      chk("grant0", glog_id[0], 0);
      chk("grant1", glog_id[1], 1);
      chk("grant2", glog_id[2], 2);
      chk("grant3", glog_id[3], 3);
      chk("grant4", glog_id[4], 0);
      for (int i = 0; i < 4; i++) chk("grant_spacing", glog_cyc[i+1] - glog_cyc[i], 4);
      chk("wr_sel", 32'(recs[0].sel), 32'h01);
      chk("wr_en_cycles", recs[0].en, 1);
      chk("wr_err", 32'(recs[0].e), 32'h0);
      chk("wr_rdata_zero", recs[0].d, 32'h0);
      chk("dec_E0", 32'(recs[1].sel), 32'h80);
      chk("dec_20", 32'(recs[2].sel), 32'h02);
      chk("unwritten_rd", recs[2].d, 32'h0012_3456);
      chk("readback", recs[4].d, 32'hA5A5_1234);
    end

    // wait states then slave error
    clear_logs();
    s_wait = 3;
    s_err  = 1'b1;
    push(2, 1'b0, 32'h0000_0100, 32'h0);
    wait_idle(100);
    chk("werr_n", recs.size(), 1);
    if (recs.size() == 1) begin
      chk("werr_en_cycles", recs[0].en, 4);
      chk("werr_err", 32'(recs[0].e), 32'h1);
      chk("werr_rdata", recs[0].d, 32'h0012_3456);
    end
    s_wait = 0;
    s_err  = 1'b0;

    // reset during ACCESS
    clear_logs();
    s_wait = 10;
    push(1, 1'b0, 32'h0000_0010, 32'h0);
    k = 0;
    do begin
      @(negedge pclk); #1;
      k++;
    end while (!penable && k < 20);
    chk("reach_access", 32'(penable), 32'h1);
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_pselx", 32'(pselx), 32'h0);
    chk("mid_rst_penable", 32'(penable), 32'h0);
    chk("mid_rst_paddr", paddr, 32'h0);
    chk("mid_rst_pwrite", 32'(pwrite), 32'h0);
    chk("mid_rst_pwdata", pwdata, 32'h0);
    chk("mid_rst_rdata", rsp_rdata, 32'h0);
    chk("mid_rst_err", 32'(rsp_err), 32'h0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    preset = 1'b0;
    s_wait = 0;
    pulses = 0;
    repeat (6) begin
      @(negedge pclk); #1;
      if (rsp_valid != '0) pulses++;
    end
    chk("no_rsp_after_rst", pulses, 0);

    // pointer restarts at 0 after reset: requester 1 ahead of 3
    clear_logs();
    push(3, 1'b0, 32'h0000_0020, 32'h0);
    push(1, 1'b0, 32'h0000_0010, 32'h0);
    wait_idle(100);
    chk("post_rst_n", glog_id.size(), 2);
    if (glog_id.size() == 2 && recs.size() == 2) begin
      chk("post_rst_g0", glog_id[0], 1);
      chk("post_rst_g1", glog_id[1], 3);
      chk("post_rst_rd1", recs[0].d, 32'hA5A5_1234);
      chk("post_rst_rd3", recs[1].d, 32'h3333_3333);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    clear_logs();
    s_wait = 1000;
    push(0, 1'b0, 32'h0000_0010, 32'h0);
    wait_idle(100);
    chk("tmo_n", recs.size(), 1);
    if (recs.size() == 1) begin
      chk("tmo_err", 32'(recs[0].e), 32'h1);
      chk("tmo_rdata", recs[0].d, 32'hDEAD_BEEF);
      chk("tmo_en_cycles", recs[0].en, 16);
    end
    clear_logs();
    s_wait = 15;
    push(0, 1'b0, 32'h0000_0010, 32'h0);
    wait_idle(100);
    chk("tmo_edge_n", recs.size(), 1);
    if (recs.size() == 1) begin
      chk("tmo_edge_err", 32'(recs[0].e), 32'h0);
      chk("tmo_edge_rdata", recs[0].d, 32'hA5A5_1234);
      chk("tmo_edge_en_cycles", recs[0].en, 16);
    end
    s_wait = 0;
`endif

    repeat (2) @(posedge pclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
